// File: rtl/noc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_sequencer_if
// Description : Bus between the run controller and the router/traffic arrays.
//               The master modport is the sequencer side. The slave modport is
//               the config/array side that drives the run controls and
//               observes the op broadcast.
//               Opcode defines are shared by every user of this bus.
//   start/max_cycle/fill_pending/net_idle/stall : run controls (to sequencer)
//   router_op/traffic_op/rt_dst/fill_idx        : op broadcast (from sequencer)
//   in_cycle/busy/finished                      : run status   (from sequencer)
// Revision    : 1.0  initial release
// ============================================================================

`ifndef NOC_SEQ_OPCODES
`define NOC_SEQ_OPCODES
`define OP_SIZE      3
`define NOP          3'd0
`define Init         3'd1
`define Fill         3'd2
`define LoadRt       3'd3
`define LoadStaging  3'd4
`define Phase0       3'd5
`define Phase1       3'd6
`endif

interface noc_sequencer_if #(
    parameter int ROUTER_BITS    = 4,
    parameter int MAX_CYCLE_BITS = 16,
    parameter int FILL_BITS      = 8
);
    logic                      start;
    logic [MAX_CYCLE_BITS-1:0] max_cycle;
    logic                      fill_pending;
    logic                      net_idle;
    logic                      stall;
    logic [`OP_SIZE-1:0]       router_op;
    logic [`OP_SIZE-1:0]       traffic_op;
    logic [ROUTER_BITS-1:0]    rt_dst;
    logic [FILL_BITS-1:0]      fill_idx;
    logic [MAX_CYCLE_BITS-1:0] in_cycle;
    logic                      busy;
    logic                      finished;

    modport master (
        input  start, max_cycle, fill_pending, net_idle, stall,
        output router_op, traffic_op, rt_dst, fill_idx, in_cycle, busy, finished
    );

    modport slave (
        output start, max_cycle, fill_pending, net_idle, stall,
        input  router_op, traffic_op, rt_dst, fill_idx, in_cycle, busy, finished
    );
endinterface

`default_nettype wire

// File: rtl/noc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : noc_sequencer
// Description : Run controller for the router/traffic mesh. Issues traffic
//               Init/Fill, router Init, routing-table load, then repeated
//               LoadStaging/Phase0/Phase1 simulation cycles until max_cycle
//               cycles complete or the network drains.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : noc_sequencer_if.master (run controls in, op broadcast/status out)
// Revision    : 1.0  initial release
// ============================================================================
module noc_sequencer #(
    parameter int ROUTER_SIZE    = 16,
    parameter int ROUTER_BITS    = 4,
    parameter int MAX_CYCLE_BITS = 16,
    parameter int FILL_BITS      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    noc_sequencer_if.master    bus
);

    localparam logic [ROUTER_BITS-1:0] RT_LAST = ROUTER_BITS'(ROUTER_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_INIT_TRAFFIC = 4'd1,
        S_FILL         = 4'd2,
        S_INIT         = 4'd3,
        S_LOAD_RT      = 4'd4,
        S_LOAD_STAGING = 4'd5,
        S_PHASE0       = 4'd6,
        S_PHASE1       = 4'd7,
        S_DONE         = 4'd8
    } state_t;

    state_t                    state_q,    state_d;
    logic [MAX_CYCLE_BITS-1:0] max_q,      max_d;
    logic [MAX_CYCLE_BITS-1:0] in_cycle_q, in_cycle_d;
    logic [FILL_BITS-1:0]      fill_idx_q, fill_idx_d;
    logic [ROUTER_BITS-1:0]    rt_dst_q,   rt_dst_d;

    logic [`OP_SIZE-1:0]       w_router_op;
    logic [`OP_SIZE-1:0]       w_traffic_op;
    logic [MAX_CYCLE_BITS-1:0] w_in_cycle_inc;

    assign w_in_cycle_inc = in_cycle_q + MAX_CYCLE_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            max_q      <= '0;
            in_cycle_q <= '0;
            fill_idx_q <= '0;
            rt_dst_q   <= '0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            in_cycle_q <= in_cycle_d;
            fill_idx_q <= fill_idx_d;
            rt_dst_q   <= rt_dst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        in_cycle_d   = in_cycle_q;
        fill_idx_d   = fill_idx_q;
        rt_dst_d     = rt_dst_q;
        w_router_op  = `NOP;
        w_traffic_op = `NOP;

        case (state_q)
            // A fresh run from either resting state starts from clean counters;
            // DONE keeps in_cycle visible until then.
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_INIT_TRAFFIC;
                    max_d      = bus.max_cycle;
                    in_cycle_d = '0;
                    fill_idx_d = '0;
                    rt_dst_d   = '0;
                end
            end
            S_INIT_TRAFFIC: begin
                w_traffic_op = `Init;
                state_d      = S_FILL;
            end
            S_FILL: begin
                if (bus.fill_pending) begin
                    w_traffic_op = `Fill;
                    // Saturate: extra fills still issue but reuse the last index.
                    if (fill_idx_q != '1) begin
                        fill_idx_d = fill_idx_q + FILL_BITS'(1);
                    end
                end else begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                w_router_op = `Init;
                rt_dst_d    = '0;
                state_d     = S_LOAD_RT;
            end
            S_LOAD_RT: begin
                w_router_op = `LoadRt;
                if (rt_dst_q == RT_LAST) begin
                    state_d = (max_q == '0) ? S_DONE : S_LOAD_STAGING;
                end else begin
                    rt_dst_d = rt_dst_q + ROUTER_BITS'(1);
                end
            end
            // Stall only gates the start of a new cycle; once LoadStaging is
            // issued, Phase0 and Phase1 always follow.
            S_LOAD_STAGING: begin
                if (!bus.stall) begin
                    w_router_op = `LoadStaging;
                    state_d     = S_PHASE0;
                end
            end
            S_PHASE0: begin
                w_router_op = `Phase0;
                state_d     = S_PHASE1;
            end
            S_PHASE1: begin
                w_router_op = `Phase1;
                in_cycle_d  = w_in_cycle_inc;
                if ((w_in_cycle_inc == max_q) || bus.net_idle) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD_STAGING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.router_op  = w_router_op;
    assign bus.traffic_op = w_traffic_op;
    assign bus.rt_dst     = rt_dst_q;
    assign bus.fill_idx   = fill_idx_q;
    assign bus.in_cycle   = in_cycle_q;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.finished   = (state_q == S_DONE);

endmodule

`default_nettype wire
